// File: rtl/sub_bytes_iter.sv
// Time-multiplexed AES SubBytes: LANES S-boxes walk a 16-byte state
// in 16/LANES beats, forward or (optionally) inverse substitution.
module sub_bytes_iter #(
  parameter int LANES  = 4,
  parameter bit INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NB = 16 / LANES;
  localparam int LB = $clog2(LANES);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } st_e;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
        LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), with 0 -> 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gmul(x, x);
    r  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] a,
    input int         n
  );
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] aff(input logic [7:0] a);
    return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3)
             ^ rotl(a, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] iaff(input logic [7:0] a);
    return rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
  endfunction

  st_e            st_q, st_d;
  logic [127:0]   work_q, work_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic           inv_q, inv_d;
  logic           load;
  logic           last;
  logic [3:0]     base;
  logic [7:0]     sb_o [LANES];

  assign base = 4'(beat_q) << LB;
  assign last = (beat_q == BW'(NB - 1));
  assign load = in_valid & in_ready;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [3:0] idx;
    logic [7:0] x;
    logic [7:0] gi;
    assign idx = base + 4'(l);
    assign x   = work_q[{idx, 3'b000} +: 8];
    if (INV_EN) begin : g_inv
      // inverse path shares the field inverter: S^-1 = inv(iaff(x))
      assign gi      = ginv(inv_q ? iaff(x) : x);
      assign sb_o[l] = inv_q ? gi : aff(gi);
    end else begin : g_fwd
      assign gi      = ginv(x);
      assign sb_o[l] = aff(gi);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      work_q <= '0;
      beat_q <= '0;
      inv_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      work_q <= work_d;
      beat_q <= beat_d;
      inv_q  <= inv_d;
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE: if (in_valid) st_d = BUSY;
      BUSY: if (last) st_d = DONE;
      DONE: if (out_ready) st_d = in_valid ? BUSY : IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst & ((st_q == IDLE) |
                       ((st_q == DONE) & out_ready));
    out_valid = (st_q == DONE);
    busy      = (st_q != IDLE);
    out_state = work_q;
  end

  always_comb begin
    work_d = work_q;
    beat_d = beat_q;
    inv_d  = inv_q;
    if (load) begin
      work_d = in_state;
      beat_d = '0;
      inv_d  = inv & INV_EN;
    end else if (st_q == BUSY) begin
      for (int l = 0; l < LANES; l++) begin
        work_d[{base + 4'(l), 3'b000} +: 8] = sb_o[l];
      end
      beat_d = (NB > 1) ? beat_q + BW'(1) : '0;
    end
  end

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Parametrised, time-multiplexed AES SubBytes engine. It applies the forward S-box, or optionally the inverse S-box, to a 16-byte AES state using LANES S-box instances per cycle. A full state therefore takes 16/LANES beats, which trades area against latency. It sits between the round-key/ShiftRows stages of the iterative cipher core and connects to them through valid/ready handshakes on both sides.

## Interface
Parameters:
- LANES, default 4: S-box instances per cycle. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- INV_EN, default 1: when 1, the inverse S-box is also instantiated per lane and the `inv` input is honoured. When 0, only the forward S-box exists and `inv` is ignored.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  engine can accept a state.
- in_state  in  128  input state. Byte k = 4*row + col occupies bits [8k+7:8k].
- inv  in  1  1 selects inverse SubBytes; sampled with in_state.
- out_valid  out  1  result state valid.
- out_ready  in  1  downstream accepts the result.
- out_state  out  128  result state, same byte layout as in_state.
- busy  out  1  1 whenever the FSM is not IDLE.

## Operation
- N = 16/LANES beats per state. The beat counter is max(1, clog2(N)) bits wide; when LANES=16 it is held at 0.
- Storage: a 128-bit work register, a beat counter, a latched mode bit `inv_q`, and a 2-bit FSM.
- FSM states:
  - IDLE: in_ready=1. On in_valid: load work ← in_state, inv_q ← inv & INV_EN, beat ← 0, then go to BUSY.
  - BUSY: each edge replaces work bytes [beat*LANES .. beat*LANES+LANES-1] with S(byte), or S⁻¹(byte) when inv_q=1. Other bytes are held. beat increments. After the beat with index N-1, go to DONE.
  - DONE: out_valid=1 and out_state=work, held stable until out_ready.
    - out_ready=1, in_valid=0: go to IDLE.
    - out_ready=1, in_valid=1: back-to-back. in_ready=1 this cycle; load the new state and go directly to BUSY.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from the FSM state and out_ready; there is no path from in_valid.
- out_state equals the work register. Its value outside DONE is don't-care to consumers, but it is deterministic (intermediate partially substituted work register).
- The S-boxes are combinational GF(2^8) lookups per FIPS-197. There are no multi-cycle S-box paths.
- in_valid is ignored while BUSY. Upstream must hold in_valid/in_state until in_ready. Changing them while in_ready=0 has no effect.

## Timing
- Reset (rst=0, asynchronous): FSM goes to IDLE, work=0, beat=0, inv_q=0, out_valid=0, busy=0, out_state=0. in_ready=0 while rst=0 and 1 from the first cycle after release.
- Latency: if a state is accepted at edge E0, out_valid rises after edge E0+N. Examples: LANES=16 gives E0+1; LANES=4 gives E0+4; LANES=1 gives E0+16.
- Throughput with out_ready held at 1: one state every N+1 cycles. Back-to-back acceptance removes the IDLE bubble, giving one state per N+1 edges per engine.
- Reset asserted mid-BUSY or in DONE: the in-flight state is discarded immediately and no out_valid is produced after release.
- out_valid never drops without an out_ready handshake.

## Test plan
- LANES=4, INV_EN=1, forward. in_state has all bytes 0x00 except byte0=0x53 and byte15=0xFF, inv=0. Required: out_valid 4 cycles after accept; byte0=0xED, byte15=0x16, all other bytes 0x63.
- Inverse round-trip. Feed the previous result with inv=1. Required: the original state returns (0x53/0x00…/0xFF), with the same latency.
- Sweep LANES ∈ {1,2,8,16} with FIPS-197 round-1 start state 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08. Required: d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30; latency 16, 8, 2, 1 respectively.
- Backpressure. Hold out_ready=0 for 10 cycles in DONE. Required: out_valid stays 1, out_state is unchanged, in_ready=0. Then set out_ready=1 with in_valid=1: the new state is accepted in the same cycle and the next out_valid arrives N edges later.
- INV_EN=0 with inv=1 and byte0=0x00. Required: byte0 out = 0x63 (forward only).
- Reset mid-operation. Assert rst=0 at beat 2 of a LANES=4 transaction. Required: out_valid=0, busy=0, out_state=0 immediately. After release in_ready=1, and a fresh state then completes normally.
